// File: rtl/mrisc_fetch_pkg.sv
// ---------------------------------------------------------------------------
// mrisc_fetch_pkg
//   Definitions shared by the fetch front end: default PC/ROM address widths,
//   the sequencer state encoding and the NOP instruction word.
//   No ports; imported by the pc_sequencer files.
// ---------------------------------------------------------------------------
package mrisc_fetch_pkg;

   localparam int PC_W_DEFAULT   = 32;
   localparam int ADDR_W_DEFAULT = 12;

   // addi x0, x0, 0 -- canonical NOP for the downstream pipeline
   localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

   // Sequencer state encoding; kept as plain constants so older tools and
   // netlists that expect a 1-bit state register stay compatible.
   typedef logic [0:0] fetch_state_t;
   localparam logic [0:0] ST_RUN    = 1'b0;
   localparam logic [0:0] ST_HALTED = 1'b1;

   function automatic logic is_halted_state(input fetch_state_t s);
      return (s == ST_HALTED);
   endfunction

endpackage

// File: rtl/pc_sequencer_if.sv
// ---------------------------------------------------------------------------
// pc_sequencer_if
//   Valid/ready channel carrying one {instruction, PC} pair per transfer from
//   the PC sequencer to the decode side.
//   Signals:
//     instr_valid  sequencer -> consumer  instr_out/instr_pc are meaningful
//     instr_ready  consumer  -> sequencer consumer accepts this cycle
//     instr_out    sequencer -> consumer  32-bit instruction (0 when idle)
//     instr_pc     sequencer -> consumer  word-address PC (0 when idle)
//   Modports: master (sequencer side), slave (consumer side).
// ---------------------------------------------------------------------------
interface pc_sequencer_if #(
   parameter int PC_W = mrisc_fetch_pkg::PC_W_DEFAULT
) ();

   logic            instr_valid;
   logic            instr_ready;
   logic [31:0]     instr_out;
   logic [PC_W-1:0] instr_pc;

   modport master (
      output instr_valid,
      output instr_out,
      output instr_pc,
      input  instr_ready
   );

   modport slave (
      input  instr_valid,
      input  instr_out,
      input  instr_pc,
      output instr_ready
   );

endinterface

// File: rtl/fetch_hold_buf.sv
// ---------------------------------------------------------------------------
// fetch_hold_buf
//   One-entry holding register for an {instruction, PC} pair. Captures the
//   ROM word that was presented but not accepted, because the ROM output is
//   only valid for the single cycle after the address was driven.
//   Ports:
//     clk      in   clock
//     rst      in   synchronous active-high reset
//     i_load   in   capture i_instr/i_pc and set valid
//     i_clear  in   drop the entry (wins over i_load)
//     i_instr  in   32-bit instruction to capture
//     i_pc     in   PC_W-bit PC to capture
//     o_valid  out  entry present
//     o_instr  out  held instruction
//     o_pc     out  held PC
// ---------------------------------------------------------------------------
module fetch_hold_buf
   import mrisc_fetch_pkg::*;
#(
   parameter int PC_W = PC_W_DEFAULT
) (
   input  logic            clk,
   input  logic            rst,
   input  logic            i_load,
   input  logic            i_clear,
   input  logic [31:0]     i_instr,
   input  logic [PC_W-1:0] i_pc,
   output logic            o_valid,
   output logic [31:0]     o_instr,
   output logic [PC_W-1:0] o_pc
);

   logic            r_valid;
   logic [31:0]     r_instr;
   logic [PC_W-1:0] r_pc;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_valid <= 1'b0;
         r_instr <= '0;
         r_pc    <= '0;
      end else if (i_clear) begin
         r_valid <= 1'b0;
      end else if (i_load) begin
         r_valid <= 1'b1;
         r_instr <= i_instr;
         r_pc    <= i_pc;
      end
   end

   assign o_valid = r_valid;
   assign o_instr = r_instr;
   assign o_pc    = r_pc;

endmodule

// File: rtl/pc_sequencer.sv
// ---------------------------------------------------------------------------
// pc_sequencer
//   Owns the program counter for the fetch stage. Drives pc_out into a ROM
//   with one cycle of read latency, pairs each returned word with the PC that
//   fetched it and offers the pair downstream over a valid/ready channel.
//   Supports stall (one-entry hold buffer), redirect (flush + new PC) and
//   halt. PCs are word addresses (+1 per instruction, wrapping).
//
//   Optional feature, macro PC_SEQ_BOUNDS_EN: a fetch at pc_q >= ROM_DEPTH is
//   not issued; instead fetch_fault is set (sticky until rst) and the
//   sequencer halts. Without the macro, fetch_fault is tied low and high PC
//   bits simply alias in the ROM.
//
//   Ports:
//     clk              in   clock
//     rst              in   synchronous active-high reset
//     pc_out           out  PC_W  registered fetch address (= pc_q)
//     rom_instr        in   32    ROM data for last cycle's pc_out
//     redirect_valid   in   1     taken branch/jump this cycle
//     redirect_target  in   PC_W  new PC on redirect
//     halt             in   1     stop issuing fetches
//     instr_bus        master modport of pc_sequencer_if (valid/ready/instr/pc)
//     halted           out  1     halted and nothing outstanding
//     fetch_fault      out  1     out-of-range fetch attempted (sticky)
// ---------------------------------------------------------------------------
module pc_sequencer
   import mrisc_fetch_pkg::*;
#(
   parameter int              PC_W      = PC_W_DEFAULT,
   parameter int              ADDR_W    = ADDR_W_DEFAULT,
   parameter logic [PC_W-1:0] RESET_PC  = '0,
   parameter int              ROM_DEPTH = 4096
) (
   input  logic              clk,
   input  logic              rst,
   output logic [PC_W-1:0]   pc_out,
   input  logic [31:0]       rom_instr,
   input  logic              redirect_valid,
   input  logic [PC_W-1:0]   redirect_target,
   input  logic              halt,
   pc_sequencer_if.master    instr_bus,
   output logic              halted,
   output logic              fetch_fault
);

`ifdef PC_SEQ_BOUNDS_EN
   localparam logic BOUNDS_EN = 1'b1;
`else
   localparam logic BOUNDS_EN = 1'b0;
`endif

   // Valid fetch window: ROM_DEPTH words, but never more than the ROM can
   // address with ADDR_W bits. One extra bit so the limit itself fits.
   localparam logic [63:0]   ROM_SPAN   = 64'd1 << ADDR_W;
   localparam logic [63:0]   ROM_WINDOW = (64'(ROM_DEPTH) < ROM_SPAN) ? 64'(ROM_DEPTH) : ROM_SPAN;
   localparam logic [PC_W:0] ROM_LIMIT  = ROM_WINDOW[PC_W:0];
   localparam logic [PC_W-1:0] PC_STEP  = {{(PC_W-1){1'b0}}, 1'b1};

   // -----------------------------------------------------------------------
   // State
   // -----------------------------------------------------------------------
   logic [PC_W-1:0] r_pc;
   fetch_state_t    r_state;
   logic            r_rsp_v;     // a fetch was issued last cycle
   logic [PC_W-1:0] r_rsp_pc;    // PC of that fetch

   logic            w_hold_v;
   logic [31:0]     w_hold_instr;
   logic [PC_W-1:0] w_hold_pc;

   logic            w_instr_valid;
   logic            w_out_free;
   logic            w_can_fetch;
   logic            w_oob;
   logic            w_issue;
   logic            w_oob_trip;
   logic            w_hold_load;
   logic            w_hold_clear;
   logic [31:0]     w_instr_mux;
   logic [PC_W-1:0] w_pc_mux;

   // -----------------------------------------------------------------------
   // Control
   // -----------------------------------------------------------------------
   // At most one word is ever outstanding (in the ROM pipe or in the hold
   // buffer), so a new fetch may only go out when the current one leaves.
   assign w_instr_valid = w_hold_v | r_rsp_v;
   assign w_out_free    = ~w_instr_valid | instr_bus.instr_ready;
   assign w_can_fetch   = (r_state == ST_RUN) & ~redirect_valid & ~halt & w_out_free;
   assign w_oob         = BOUNDS_EN & ({1'b0, r_pc} >= ROM_LIMIT);
   assign w_issue       = w_can_fetch & ~w_oob;
   assign w_oob_trip    = w_can_fetch & w_oob;

   // The ROM word is only on rom_instr for one cycle; park it if the
   // consumer is not taking it. A redirect discards it instead.
   assign w_hold_load   = r_rsp_v & ~instr_bus.instr_ready & ~redirect_valid;
   assign w_hold_clear  = redirect_valid | (w_hold_v & instr_bus.instr_ready);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_pc     <= RESET_PC;
         r_state  <= ST_RUN;
         r_rsp_v  <= 1'b0;
         r_rsp_pc <= '0;
      end else if (redirect_valid) begin
         // Redirect beats halt and issue; a simultaneous halt still lands
         // in HALTED, but at the new PC.
         r_pc    <= redirect_target;
         r_rsp_v <= 1'b0;
         r_state <= halt ? ST_HALTED : ST_RUN;
      end else begin
         r_rsp_v <= w_issue;
         if (w_issue) begin
            r_rsp_pc <= r_pc;
            r_pc     <= r_pc + PC_STEP;
         end
         if (halt | w_oob_trip) begin
            r_state <= ST_HALTED;
         end
      end
   end

   fetch_hold_buf #(
      .PC_W (PC_W)
   ) u_hold (
      .clk     (clk),
      .rst     (rst),
      .i_load  (w_hold_load),
      .i_clear (w_hold_clear),
      .i_instr (rom_instr),
      .i_pc    (r_rsp_pc),
      .o_valid (w_hold_v),
      .o_instr (w_hold_instr),
      .o_pc    (w_hold_pc)
   );

`ifdef PC_SEQ_BOUNDS_EN
   logic r_fault;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_fault <= 1'b0;
      end else if (w_oob_trip) begin
         r_fault <= 1'b1;
      end
   end

   assign fetch_fault = r_fault;
`else
   assign fetch_fault = 1'b0;
`endif

   // -----------------------------------------------------------------------
   // Output mux: held word first, then the live ROM word, else zeros
   // -----------------------------------------------------------------------
   always_comb begin
      w_instr_mux = '0;
      w_pc_mux    = '0;
      if (w_hold_v) begin
         w_instr_mux = w_hold_instr;
         w_pc_mux    = w_hold_pc;
      end else if (r_rsp_v) begin
         w_instr_mux = rom_instr;
         w_pc_mux    = r_rsp_pc;
      end
   end

   assign instr_bus.instr_valid = w_instr_valid;
   assign instr_bus.instr_out   = w_instr_mux;
   assign instr_bus.instr_pc    = w_pc_mux;

   assign pc_out = r_pc;
   assign halted = is_halted_state(r_state) & ~r_rsp_v & ~w_hold_v;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps
// ---------------------------------------------------------------------------
// tb_pc_sequencer
//   Directed bench for pc_sequencer. The main DUT (large ROM) is compared
//   every cycle against a one-slot transaction model; a second DUT with an
//   8-word ROM covers the out-of-range behaviour. Literal expectations pin
//   the model at the interesting points.
// ---------------------------------------------------------------------------
module tb_pc_sequencer;

   localparam int PC_W   = 32;
   localparam int ADDR_W = 12;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            ready = 1'b0;
   logic            redirect_valid = 1'b0;
   logic [PC_W-1:0] redirect_target = '0;
   logic            halt = 1'b0;

   logic [PC_W-1:0] pc_out, pc_out_b;
   logic [31:0]     rom_instr = '0, rom_instr_b = '0;
   logic            halted, halted_b, fetch_fault, fetch_fault_b;

   pc_sequencer_if #(.PC_W(PC_W)) bus ();
   pc_sequencer_if #(.PC_W(PC_W)) bus_b ();

   assign bus.instr_ready   = ready;
   assign bus_b.instr_ready = ready;

   pc_sequencer #(
      .PC_W(PC_W), .ADDR_W(ADDR_W), .RESET_PC('0), .ROM_DEPTH(4096)
   ) dut (
      .clk(clk), .rst(rst), .pc_out(pc_out), .rom_instr(rom_instr),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt(halt), .instr_bus(bus), .halted(halted), .fetch_fault(fetch_fault)
   );

   pc_sequencer #(
      .PC_W(PC_W), .ADDR_W(ADDR_W), .RESET_PC('0), .ROM_DEPTH(8)
   ) dut_b (
      .clk(clk), .rst(rst), .pc_out(pc_out_b), .rom_instr(rom_instr_b),
      .redirect_valid(redirect_valid), .redirect_target(redirect_target),
      .halt(halt), .instr_bus(bus_b), .halted(halted_b), .fetch_fault(fetch_fault_b)
   );

   always #5 clk = ~clk;

   // ROMs: one cycle latency, mem[a] = A000_0000 + a on the low ADDR_W bits
   always @(posedge clk) begin
      rom_instr   <= 32'hA000_0000 + {20'd0, pc_out[ADDR_W-1:0]};
      rom_instr_b <= 32'hA000_0000 + {20'd0, pc_out_b[ADDR_W-1:0]};
   end

   // -----------------------------------------------------------------------
   // Model: at most one outstanding word, tracked as a single slot no matter
   // whether it sits in the ROM pipe or is being held.
   // -----------------------------------------------------------------------
`ifdef PC_SEQ_BOUNDS_EN
   localparam bit M_BOUNDS = 1'b1;
`else
   localparam bit M_BOUNDS = 1'b0;
`endif
   localparam int M_DEPTH = 4096;

   logic [PC_W-1:0] m_pc;
   logic            m_hlt_st;
   logic            m_pend;
   logic [PC_W-1:0] m_pend_pc;
   logic            m_fault;

   always @(posedge clk) begin
      if (rst) begin
         m_pc      <= '0;
         m_hlt_st  <= 1'b0;
         m_pend    <= 1'b0;
         m_pend_pc <= '0;
         m_fault   <= 1'b0;
      end else if (redirect_valid) begin
         m_pc     <= redirect_target;
         m_pend   <= 1'b0;
         m_hlt_st <= halt;
      end else begin
         if (m_pend && ready) begin
            m_pend <= 1'b0;
            $display("accept pc=%08h instr=%08h", m_pend_pc, 32'hA000_0000 + {20'd0, m_pend_pc[11:0]});
         end
         if (halt) begin
            m_hlt_st <= 1'b1;
         end else if (!m_hlt_st && (!m_pend || ready)) begin
            if (M_BOUNDS && m_pc >= M_DEPTH) begin
               m_fault  <= 1'b1;
               m_hlt_st <= 1'b1;
            end else begin
               m_pend    <= 1'b1;
               m_pend_pc <= m_pc;
               m_pc      <= m_pc + 1;
            end
         end
      end
   end

   // -----------------------------------------------------------------------
   // Checking
   // -----------------------------------------------------------------------
   int total = 0;
   int bad   = 0;
   bit chk_en = 1'b0;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Advance one cycle and compare the main DUT with the model at negedge.
   task automatic tick();
      @(posedge clk);
      @(negedge clk);
      if (chk_en) begin
         check("m_valid",  {31'd0, bus.instr_valid}, {31'd0, m_pend});
         check("m_pc",     bus.instr_pc, m_pend ? m_pend_pc : '0);
         check("m_instr",  bus.instr_out,
               m_pend ? (32'hA000_0000 + {20'd0, m_pend_pc[11:0]}) : 32'd0);
         check("m_pc_out", pc_out, m_pc);
         check("m_halted", {31'd0, halted}, {31'd0, m_hlt_st & ~m_pend});
         check("m_fault",  {31'd0, fetch_fault}, {31'd0, m_fault});
      end
   endtask

   task automatic redirect_to(input logic [PC_W-1:0] tgt, input logic with_halt);
      redirect_valid  = 1'b1;
      redirect_target = tgt;
      halt            = with_halt;
      tick();
      redirect_valid  = 1'b0;
      halt            = 1'b0;
   endtask

   localparam logic [15:0] READY_PAT = 16'b1101_0011_1001_0110;

   initial begin
      // Reset
      tick();
      chk_en = 1'b1;
      tick();
      tick();
      check("rst_pc_out", pc_out, 32'h0);
      check("rst_valid",  {31'd0, bus.instr_valid}, 32'd0);
      check("rst_instr",  bus.instr_out, 32'd0);
      check("rst_halted", {31'd0, halted}, 32'd0);
      check("rst_fault",  {31'd0, fetch_fault}, 32'd0);

      // Streaming from reset: first word on the 2nd cycle after deassert
      rst   = 1'b0;
      ready = 1'b1;
      tick();
      check("first_valid", {31'd0, bus.instr_valid}, 32'd1);
      check("first_pc",    bus.instr_pc, 32'h0);
      check("first_instr", bus.instr_out, 32'hA000_0000);
      tick();
      check("stream_pc1", bus.instr_pc, 32'h1);
      tick();
      check("stream_pc2", bus.instr_pc, 32'h2);
      check("stream_in2", bus.instr_out, 32'hA000_0002);
      tick();
      check("stream_pc3", bus.instr_pc, 32'h3);

      // Stall three cycles on pc 3
      ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         check("stall_pc",     bus.instr_pc, 32'h3);
         check("stall_instr",  bus.instr_out, 32'hA000_0003);
         check("stall_pc_out", pc_out, 32'h4);
         if (i < 2) tick();
      end
      ready = 1'b1;
      tick();
      check("resume_pc4", bus.instr_pc, 32'h4);
      tick();
      check("resume_pc5", bus.instr_pc, 32'h5);

      // Redirect while pc 5 is presented and not accepted
      ready = 1'b0;
      redirect_to(32'h40, 1'b0);
      ready = 1'b1;
      check("redir_flush",  {31'd0, bus.instr_valid}, 32'd0);
      check("redir_pc_out", pc_out, 32'h40);
      tick();
      check("redir_pc40", bus.instr_pc, 32'h40);
      check("redir_in40", bus.instr_out, 32'hA000_0040);
      tick();
      check("redir_pc41", bus.instr_pc, 32'h41);

      // Halt while pc 7 is outstanding
      redirect_to(32'h6, 1'b0);
      tick();
      check("pre_halt_pc6", bus.instr_pc, 32'h6);
      tick();
      check("pre_halt_pc7", bus.instr_pc, 32'h7);
      halt = 1'b1;
      tick();
      halt = 1'b0;
      check("halt_no8",     {31'd0, bus.instr_valid}, 32'd0);
      check("halt_halted",  {31'd0, halted}, 32'd1);
      check("halt_pc_out",  pc_out, 32'h8);
      tick();
      check("halt_stays",   {31'd0, halted}, 32'd1);

      // Leave HALTED by redirect
      redirect_to(32'h10, 1'b0);
      check("unhalt_halted", {31'd0, halted}, 32'd0);
      tick();
      check("unhalt_pc10",   bus.instr_pc, 32'h10);

      // Redirect + halt together
      redirect_to(32'h20, 1'b1);
      check("rh_pc_out", pc_out, 32'h20);
      check("rh_halted", {31'd0, halted}, 32'd1);
      check("rh_valid",  {31'd0, bus.instr_valid}, 32'd0);
      tick();
      check("rh_no_issue", pc_out, 32'h20);

      // Reset while a word is held
      redirect_to(32'h30, 1'b0);
      tick();
      ready = 1'b0;
      tick();
      check("held_pc30", bus.instr_pc, 32'h30);
      rst = 1'b1;
      tick();
      check("midrst_valid",  {31'd0, bus.instr_valid}, 32'd0);
      check("midrst_pc_out", pc_out, 32'h0);

      // Run from 0 into the 8-word ROM limit of dut_b
      rst   = 1'b0;
      ready = 1'b1;
      for (int i = 0; i < 8; i++) begin
         tick();
         check("bnd_pc", bus_b.instr_pc, i);
      end
      tick();
`ifdef PC_SEQ_BOUNDS_EN
      check("bnd_valid",  {31'd0, bus_b.instr_valid}, 32'd0);
      check("bnd_fault",  {31'd0, fetch_fault_b}, 32'd1);
      check("bnd_halted", {31'd0, halted_b}, 32'd1);
`else
      check("alias_pc8",   bus_b.instr_pc, 32'h8);
      check("alias_in8",   bus_b.instr_out, 32'hA000_0008);
      check("alias_fault", {31'd0, fetch_fault_b}, 32'd0);
`endif

      // Irregular ready pattern on the main DUT, model checked each cycle
      for (int i = 0; i < 16; i++) begin
         ready = READY_PAT[i];
         tick();
      end
      ready = 1'b1;
      tick();
      tick();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
